// File: rtl/ir_key_decoder.sv
// IR key decoder: maps NEC codes to key indices through a CPU-written table and
// emits single-cycle press and timed auto-repeat events while a code is held.
module ir_key_decoder #(
  parameter int unsigned IDX_W           = 4,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_INTERVAL = 5000000
) (
  input  logic             clk50,
  input  logic             reset_n,
  input  logic [31:0]      ir_code,
  input  logic             ir_code_ack,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [31:0]      tbl_code,
  output logic             key_valid,
  output logic [IDX_W-1:0] key_idx,
  output logic             key_repeat,
  output logic             key_held,
  output logic             ir_unknown
);

  localparam int unsigned NUM_KEYS = 2 ** IDX_W;
  localparam int unsigned TMR_W    = 25;
  localparam logic [TMR_W-1:0] DELAY_LAST    = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] INTERVAL_LAST = TMR_W'(REPEAT_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEATING} state_t;

  logic [31:0]      code_tbl [NUM_KEYS];
  logic             match_hit;
  logic [IDX_W-1:0] match_idx;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [31:0]      hold_code_q, hold_code_d;
  logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
  logic             key_valid_d, key_repeat_d, key_held_d, ir_unknown_d;
  logic [IDX_W-1:0] key_idx_d;

  // Code table; a zero entry is disabled
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) code_tbl[i] <= '0;
    end else if (tbl_we) begin
      code_tbl[tbl_idx] <= tbl_code;
    end
  end

  // Priority match: iterate downward so the lowest matching index wins
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (code_tbl[i] != 32'd0 && code_tbl[i] == ir_code) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      hold_code_q <= '0;
      hold_idx_q  <= '0;
      key_valid   <= 1'b0;
      key_idx     <= '0;
      key_repeat  <= 1'b0;
      key_held    <= 1'b0;
      ir_unknown  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      hold_code_q <= hold_code_d;
      hold_idx_q  <= hold_idx_d;
      key_valid   <= key_valid_d;
      key_idx     <= key_idx_d;
      key_repeat  <= key_repeat_d;
      key_held    <= key_held_d;
      ir_unknown  <= ir_unknown_d;
    end
  end

  // Next state: ack > table-write release > code release > timer event
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hold_code_d  = hold_code_q;
    hold_idx_d   = hold_idx_q;
    key_valid_d  = 1'b0;
    key_idx_d    = key_idx;
    key_repeat_d = key_repeat;
    key_held_d   = key_held;
    ir_unknown_d = 1'b0;

    if (ir_code_ack) begin
      timer_d = '0;
      if (match_hit) begin
        key_valid_d  = 1'b1;
        key_repeat_d = 1'b0;
        key_idx_d    = match_idx;
        key_held_d   = 1'b1;
        hold_code_d  = ir_code;
        hold_idx_d   = match_idx;
        state_d      = PRESSED;
      end else begin
        ir_unknown_d = 1'b1;
        key_held_d   = 1'b0;
        state_d      = IDLE;
      end
    end else if (state_q != IDLE) begin
      if ((tbl_we && tbl_idx == hold_idx_q) || ir_code != hold_code_q) begin
        key_held_d = 1'b0;
        timer_d    = '0;
        state_d    = IDLE;
      end else if (timer_q == ((state_q == PRESSED) ? DELAY_LAST : INTERVAL_LAST)) begin
        key_valid_d  = 1'b1;
        key_repeat_d = 1'b1;
        key_idx_d    = hold_idx_q;
        timer_d      = '0;
        state_d      = REPEATING;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ir_key_decoder.sv
// Scoreboard bench for ir_key_decoder: stimulus queues expected events with their
// arrival cycle; a negedge monitor pops and compares each event the DUT emits.
module tb_ir_key_decoder;

  localparam int unsigned IDX_W = 4;
  localparam logic [31:0] C1 = 32'h20DF10EF;
  localparam logic [31:0] C2 = 32'h20DF08F7;
  localparam logic [31:0] C3 = 32'hAA55FF00;
  localparam logic [31:0] C4 = 32'h20DF8877;

  logic             clk50 = 1'b0;
  logic             reset_n;
  logic [31:0]      ir_code;
  logic             ir_code_ack;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_idx;
  logic [31:0]      tbl_code;
  logic             key_valid;
  logic [IDX_W-1:0] key_idx;
  logic             key_repeat;
  logic             key_held;
  logic             ir_unknown;

  ir_key_decoder #(.IDX_W(IDX_W), .REPEAT_DELAY(100), .REPEAT_INTERVAL(20)) dut (
    .clk50(clk50), .reset_n(reset_n), .ir_code(ir_code), .ir_code_ack(ir_code_ack),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_code(tbl_code),
    .key_valid(key_valid), .key_idx(key_idx), .key_repeat(key_repeat),
    .key_held(key_held), .ir_unknown(ir_unknown)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    bit               unk;
    logic [IDX_W-1:0] idx;
    bit               rep;
    int               cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  passed = 0;

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic push_key(input int idx, input bit rep, input int at);
    ev_t e;
    e.unk = 1'b0; e.idx = IDX_W'(idx); e.rep = rep; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic push_unk(input int at);
    ev_t e;
    e.unk = 1'b1; e.idx = '0; e.rep = 1'b0; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic tbl_write(input int idx, input logic [31:0] code);
    tbl_we = 1'b1; tbl_idx = IDX_W'(idx); tbl_code = code;
    step(1);
    tbl_we = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the expected queue exactly
  always @(negedge clk50) begin
    if (key_valid || ir_unknown) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL event: unexpected valid=%0b unk=%0b idx=%0d rep=%0b at cycle %0d",
                 key_valid, ir_unknown, key_idx, key_repeat, cyc);
      end else begin
        ev_t e;
        bit  ok;
        e = exp_q.pop_front();
        if (e.unk) ok = ir_unknown && !key_valid && cyc == e.cyc;
        else       ok = key_valid && !ir_unknown && key_idx == e.idx &&
                        key_repeat == e.rep && cyc == e.cyc;
        if (ok) passed++;
        else $display("FAIL event: got valid=%0b unk=%0b idx=%0d rep=%0b cyc=%0d expected unk=%0b idx=%0d rep=%0b cyc=%0d",
                      key_valid, ir_unknown, key_idx, key_repeat, cyc, e.unk, e.idx, e.rep, e.cyc);
      end
    end
  end

  initial begin
    int t;
    reset_n = 1'b0; ir_code = '0; ir_code_ack = 1'b0;
    tbl_we = 1'b0; tbl_idx = '0; tbl_code = '0;
    step(3);
    chk("reset_outputs", int'({key_valid, key_repeat, key_held, ir_unknown, key_idx}), 0);
    reset_n = 1'b1;
    step(2);

    // 1: press, delayed then periodic repeats, release
    tbl_write(3, C1);
    t = cyc; ir_code = C1; ir_code_ack = 1'b1;
    push_key(3, 0, t + 1);
    for (int j = 0; j < 10; j++) push_key(3, 1, t + 101 + 20 * j);
    step(1); ir_code_ack = 1'b0;
    step(298);
    chk("t1_held", int'(key_held), 1);
    step(1); ir_code = '0;
    step(1);
    chk("t1_released", int'(key_held), 0);

    // 2: unknown code
    tbl_write(3, 32'd0);
    t = cyc; ir_code = C2; ir_code_ack = 1'b1;
    push_unk(t + 1);
    step(1); ir_code_ack = 1'b0;
    step(5);
    chk("t2_not_held", int'(key_held), 0);
    ir_code = '0;
    step(2);

    // 3: lowest index wins; write in the ack cycle uses old contents
    tbl_write(1, C3);
    tbl_write(5, C3);
    t = cyc; ir_code = C3; ir_code_ack = 1'b1;
    tbl_we = 1'b1; tbl_idx = 4'd1; tbl_code = '0;
    push_key(1, 0, t + 1);
    step(1); ir_code_ack = 1'b0; tbl_we = 1'b0;
    step(2);
    chk("t3_held", int'(key_held), 1);
    ir_code_ack = 1'b1;
    push_key(5, 0, t + 4);
    step(1); ir_code_ack = 1'b0;
    step(10); ir_code = '0;
    step(1);
    chk("t3_released", int'(key_held), 0);

    // 4: new mapped code while repeating restarts timing
    tbl_write(3, C1);
    tbl_write(7, C4);
    t = cyc; ir_code = C1; ir_code_ack = 1'b1;
    push_key(3, 0, t + 1);
    push_key(3, 1, t + 101);
    step(1); ir_code_ack = 1'b0;
    step(109);
    ir_code = C4; ir_code_ack = 1'b1;
    push_key(7, 0, t + 111);
    push_key(7, 1, t + 211);
    push_key(7, 1, t + 231);
    step(1); ir_code_ack = 1'b0;
    step(129); ir_code = '0;
    step(1);
    chk("t4_released", int'(key_held), 0);

    // 5: rewriting the held entry releases even with an identical code
    t = cyc; ir_code = C1; ir_code_ack = 1'b1;
    push_key(3, 0, t + 1);
    step(1); ir_code_ack = 1'b0;
    step(49);
    chk("t5_held", int'(key_held), 1);
    tbl_we = 1'b1; tbl_idx = 4'd3; tbl_code = C1;
    step(1); tbl_we = 1'b0;
    chk("t5_released", int'(key_held), 0);
    step(150); ir_code = '0;
    step(2);

    // 6: async reset mid-repeat clears outputs and table
    t = cyc; ir_code = C1; ir_code_ack = 1'b1;
    push_key(3, 0, t + 1);
    push_key(3, 1, t + 101);
    step(1); ir_code_ack = 1'b0;
    step(109);
    chk("t6_held_before", int'(key_held), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_reset", int'({key_valid, key_repeat, key_held, ir_unknown, key_idx}), 0);
    step(2); reset_n = 1'b1;
    step(150);
    chk("t6_no_hold_after_reset", int'(key_held), 0);
    ir_code_ack = 1'b1;
    push_unk(cyc + 1);
    step(1); ir_code_ack = 1'b0; ir_code = '0;
    step(5);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
